// File: rtl/calc_pkg.sv
// calc_pkg: opcodes, arbiter state encoding and operand width shared by the
// calculator unit arbiter and its round-robin picker.
package calc_pkg;

  localparam int OPW = 16;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  // An opcode is legal only when it is exactly one of the three one-hot codes.
  function automatic logic op_legal(input logic [2:0] o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_MUL);
  endfunction

endpackage

// File: rtl/calc_unit_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector. Returns the first asserted
// request at or after ptr_i, wrapping around NREQ.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic            valid_o,
  output logic [PW-1:0]   winner_o
);

  int idx_s;

  // Scan offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx_s    = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx_s = (int'(ptr_i) + i) % NREQ;
      if (req_i[idx_s[PW-1:0]]) begin
        valid_o  = 1'b1;
        winner_o = idx_s[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/calc_unit_arbiter.sv
// calc_unit_arbiter: shares one add/sub unit and one multiply unit between
// NREQ requesters, one operation in flight at a time, round-robin grants.
// Optional WAIT watchdog enabled by defining CALC_ARB_TIMEOUT_EN.
module calc_unit_arbiter
  import calc_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*3-1:0] op,
  input  logic [NREQ*OPW-1:0] opa,
  input  logic [NREQ*OPW-1:0] opb,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [OPW-1:0]    result,
  output logic              err,
  output logic [OPW-1:0]    alu_in1,
  output logic [OPW-1:0]    alu_in2,
  output logic              alu_sub,
  output logic              alu_start,
  input  logic [OPW-1:0]    alu_out,
  input  logic              alu_finish,
  output logic [OPW-1:0]    mul_in1,
  output logic [OPW-1:0]    mul_in2,
  output logic              mul_start,
  input  logic [OPW-1:0]    mul_out,
  input  logic              mul_finish
);

  localparam int PW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1'b1);

  arb_state_t      state_q;
  logic [PW-1:0]   rr_q, win_q;
  logic [2:0]      op_q;
  logic [OPW-1:0]  opa_q, opb_q;
  logic [NREQ-1:0] gnt_q, done_q;
  logic [OPW-1:0]  result_q, alu_in1_q, alu_in2_q, mul_in1_q, mul_in2_q;
  logic            err_q, alu_sub_q, alu_start_q, mul_start_q;

  logic            pick_valid_s;
  logic [PW-1:0]   pick_win_s;
  logic [2:0]      op_sel_s;
  logic [OPW-1:0]  opa_sel_s, opb_sel_s;
  logic            fin_sel_s;
  logic [OPW-1:0]  out_sel_s;

`ifdef CALC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q;
`endif

  rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
    .req_i    (req),
    .ptr_i    (rr_q),
    .valid_o  (pick_valid_s),
    .winner_o (pick_win_s)
  );

  // Route the winning requester's op/operands and the selected unit's finish.
  always_comb begin
    op_sel_s  = op[int'(pick_win_s) * 3 +: 3];
    opa_sel_s = opa[int'(pick_win_s) * OPW +: OPW];
    opb_sel_s = opb[int'(pick_win_s) * OPW +: OPW];
    if (op_q == OP_MUL) begin
      fin_sel_s = mul_finish;
      out_sel_s = mul_out;
    end else begin
      fin_sel_s = alu_finish;
      out_sel_s = alu_out;
    end
  end

  // Arbiter FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      win_q       <= '0;
      op_q        <= 3'b000;
      opa_q       <= '0;
      opb_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_sub_q   <= 1'b0;
      alu_start_q <= 1'b0;
      mul_in1_q   <= '0;
      mul_in2_q   <= '0;
      mul_start_q <= 1'b0;
`ifdef CALC_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      gnt_q       <= '0;
      done_q      <= '0;
      alu_start_q <= 1'b0;
      mul_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid_s) begin
            win_q <= pick_win_s;
            op_q  <= op_sel_s;
            opa_q <= opa_sel_s;
            opb_q <= opb_sel_s;
            gnt_q <= ONE_HOT0 << pick_win_s;
            if (op_legal(op_sel_s)) begin
              state_q <= ISSUE;
            end else begin
              result_q <= '0;
              err_q    <= 1'b1;
              state_q  <= RESPOND;
            end
          end
        end
        ISSUE: begin
          if (op_q == OP_MUL) begin
            mul_in1_q   <= opa_q;
            mul_in2_q   <= opb_q;
            mul_start_q <= 1'b1;
          end else begin
            alu_in1_q   <= opa_q;
            alu_in2_q   <= opb_q;
            alu_sub_q   <= (op_q == OP_SUB);
            alu_start_q <= 1'b1;
          end
`ifdef CALC_ARB_TIMEOUT_EN
          cnt_q <= '0;
`endif
          state_q <= WAIT;
        end
        WAIT: begin
          if (fin_sel_s) begin
            result_q <= out_sel_s;
            err_q    <= 1'b0;
            state_q  <= RESPOND;
          end
`ifdef CALC_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            result_q <= '0;
            err_q    <= 1'b1;
            state_q  <= RESPOND;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        RESPOND: begin
          done_q  <= ONE_HOT0 << win_q;
          rr_q    <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign alu_sub   = alu_sub_q;
  assign alu_start = alu_start_q;
  assign mul_in1   = mul_in1_q;
  assign mul_in2   = mul_in2_q;
  assign mul_start = mul_start_q;

endmodule

// File: tb/tb_calc_unit_arbiter.sv
// tb_calc_unit_arbiter: directed bench with behavioural add/sub and multiply
// units and a scoreboard of expected (requester, result, err) completions.
module tb_calc_unit_arbiter;
  import calc_pkg::*;

  localparam int ALU_LAT = 3;
  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [5:0]  op = 6'd0;
  logic [31:0] opa = 32'd0, opb = 32'd0;
  logic [1:0]  gnt, done;
  logic [15:0] result, alu_in1, alu_in2, mul_in1, mul_in2;
  logic        err, alu_sub, alu_start, mul_start;
  logic [15:0] alu_out, mul_out;
  logic        alu_finish, mul_finish;

  int n_assert = 0;
  int n_fail   = 0;
  int alu_starts = 0, mul_starts = 0, cyc = 0;
  int alu_cnt, mul_cnt;
  bit mul_hang = 1'b0, spur_alu = 1'b0;

  typedef struct {int idx; logic [15:0] res; logic err;} exp_t;
  exp_t sb[$];

  calc_unit_arbiter #(.NREQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .nRST(nRST), .req(req), .op(op), .opa(opa), .opb(opb),
    .gnt(gnt), .done(done), .result(result), .err(err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sub(alu_sub), .alu_start(alu_start),
    .alu_out(alu_out), .alu_finish(alu_finish),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_start(mul_start),
    .mul_out(mul_out), .mul_finish(mul_finish)
  );

  always #5 clk = ~clk;

  // Cycle counter and unit start counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_start) alu_starts <= alu_starts + 1;
    if (mul_start) mul_starts <= mul_starts + 1;
  end

  // Add/sub unit model: finish ALU_LAT cycles after start; optional spurious finish.
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      alu_finish <= 1'b0; alu_out <= 16'd0; alu_cnt <= 0;
    end else begin
      alu_finish <= 1'b0;
      if (alu_start) alu_cnt <= ALU_LAT;
      else if (alu_cnt != 0) begin
        alu_cnt <= alu_cnt - 1;
        if (alu_cnt == 1) begin
          alu_finish <= 1'b1;
          alu_out <= alu_sub ? (alu_in1 - alu_in2) : (alu_in1 + alu_in2);
        end
      end
      if (spur_alu && alu_cnt == 0) begin
        alu_finish <= 1'b1; alu_out <= 16'h1234;
      end
    end
  end

  // Multiply unit model: finish MUL_LAT cycles after start unless hung.
  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      mul_finish <= 1'b0; mul_out <= 16'd0; mul_cnt <= 0;
    end else begin
      mul_finish <= 1'b0;
      if (mul_start) mul_cnt <= MUL_LAT;
      else if (mul_cnt != 0) begin
        mul_cnt <= mul_cnt - 1;
        if (mul_cnt == 1 && !mul_hang) begin
          mul_finish <= 1'b1;
          mul_out <= 16'(mul_in1 * mul_in2);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    op[i*3 +: 3]   = o;
    opa[i*16 +: 16] = a;
    opb[i*16 +: 16] = b;
  endtask

  task automatic wait_gnt(input int idx, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (gnt !== 2'b00) begin seen = 1'b1; break; end
    end
    if (!seen) check({tag, "_gnt_timeout"}, 32'd0, 32'd1);
    else check({tag, "_gnt"}, 32'(gnt), 32'd1 << idx);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    exp_t e;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done !== 2'b00) begin seen = 1'b1; break; end
    end
    if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    else if (sb.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
    else begin
      e = sb.pop_front();
      check({tag, "_done"}, 32'(done), 32'd1 << e.idx);
      check({tag, "_result"}, 32'(result), 32'(e.res));
      check({tag, "_err"}, 32'(err), 32'(e.err));
    end
  endtask

  task automatic wait_mul_start(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mul_start === 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) check({tag, "_mul_start_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int a0, m0, t0;
    // Reset state
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_starts", {30'd0, alu_start, mul_start}, 32'd0);
    check("rst_ops", {alu_in1, mul_in1}, 32'd0);

    // Add on requester 0: 12 + 30
    a0 = alu_starts; m0 = mul_starts;
    set_op(0, OP_ADD, 16'd12, 16'd30);
    req = 2'b01;
    sb.push_back('{idx: 0, res: 16'd42, err: 1'b0});
    wait_gnt(0, "add");
    req = 2'b00;
    wait_done("add");
    check("add_alu_sub", 32'(alu_sub), 32'd0);
    check("add_alu_starts", 32'(alu_starts - a0), 32'd1);
    check("add_mul_starts", 32'(mul_starts - m0), 32'd0);

    // Stray alu finish in IDLE must not produce a completion
    spur_alu = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_finish_ignored", {gnt, done}, 32'd0);

    // Multiply on requester 1: -7 * 10, with alu finish noise throughout
    m0 = mul_starts;
    set_op(1, OP_MUL, 16'hFFF9, 16'd10);
    req = 2'b10;
    sb.push_back('{idx: 1, res: 16'hFFBA, err: 1'b0});
    wait_gnt(1, "mul");
    req = 2'b00;
    wait_done("mul");
    spur_alu = 1'b0;
    check("mul_starts", 32'(mul_starts - m0), 32'd1);

    // Both held: grant order 0,1,0,1 with 5 - 9
    set_op(0, OP_SUB, 16'd5, 16'd9);
    set_op(1, OP_SUB, 16'd5, 16'd9);
    req = 2'b11;
    for (int i = 0; i < 4; i++) sb.push_back('{idx: i % 2, res: 16'hFFFC, err: 1'b0});
    for (int i = 0; i < 4; i++) begin
      wait_gnt(i % 2, $sformatf("rr%0d", i));
      if (i == 3) req = 2'b00;
      wait_done($sformatf("rr%0d", i));
    end
    check("sub_alu_sub", 32'(alu_sub), 32'd1);

    // Illegal opcode: error completion, no unit started
    a0 = alu_starts; m0 = mul_starts;
    set_op(0, 3'b011, 16'd1, 16'd2);
    req = 2'b01;
    sb.push_back('{idx: 0, res: 16'd0, err: 1'b1});
    wait_gnt(0, "ill");
    req = 2'b00;
    wait_done("ill");
    check("ill_no_start", 32'((alu_starts - a0) + (mul_starts - m0)), 32'd0);

    // Reset during WAIT
    mul_hang = 1'b1;
    set_op(1, OP_MUL, 16'd3, 16'd4);
    req = 2'b10;
    wait_gnt(1, "rstw");
    req = 2'b00;
    wait_mul_start("rstw");
    @(negedge clk);
    check("rstw_pre_mul_in1", 32'(mul_in1), 32'd3);
    nRST = 1'b0;
    #1;
    check("rstw_outs", {gnt, done, err, alu_start, mul_start, alu_sub, 2'd0, result}, 32'd0);
    check("rstw_operands", {mul_in1, alu_in1}, 32'd0);
    @(negedge clk);
    nRST = 1'b1;
    mul_hang = 1'b0;
    set_op(0, OP_ADD, 16'd1, 16'd1);
    set_op(1, OP_ADD, 16'd2, 16'd3);
    req = 2'b11;
    sb.push_back('{idx: 0, res: 16'd2, err: 1'b0});
    wait_gnt(0, "post_rst_both");
    req = 2'b00;
    wait_done("post_rst_both");
    nRST = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    req = 2'b10;
    sb.push_back('{idx: 1, res: 16'd5, err: 1'b0});
    wait_gnt(1, "post_rst_one");
    req = 2'b00;
    wait_done("post_rst_one");

`ifdef CALC_ARB_TIMEOUT_EN
    // Watchdog: multiply never finishes
    mul_hang = 1'b1;
    set_op(0, OP_MUL, 16'd6, 16'd7);
    req = 2'b01;
    sb.push_back('{idx: 0, res: 16'd0, err: 1'b1});
    wait_gnt(0, "tmo");
    req = 2'b00;
    wait_mul_start("tmo");
    t0 = cyc;
    wait_done("tmo");
    check("tmo_not_early", 32'((cyc - t0) >= 8), 32'd1);
    mul_hang = 1'b0;
    req = 2'b01;
    sb.push_back('{idx: 0, res: 16'd42, err: 1'b0});
    wait_gnt(0, "tmo_next");
    req = 2'b00;
    wait_done("tmo_next");
`else
    t0 = 0;
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_unit_arbiter.md
Name: calc_unit_arbiter

Overview:
- Shares one addition unit (add/sub) and one multiply unit between NREQ requesters, e.g. the operand-entry sequencer (digit×10 + key) and the result path of the calculator controller.
- Each requester issues an op with two 16-bit operands. The arbiter grants round-robin, pulses start to the matching unit, waits for its finish, then returns the result to the winner.
- Only one operation is in flight at a time, across both units.

Parameters:
- NREQ, 2, number of requesters. Supported values: 2..4.
- TIMEOUT_CYCLES, 64, WAIT-state watchdog limit. Used only with CALC_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request level.
- op  input  NREQ×3  per-requester opcode: 001 add, 010 sub, 100 mul.
- opa  input  NREQ×16  per-requester operand 1.
- opb  input  NREQ×16  per-requester operand 2.
- gnt  output  NREQ  one-cycle pulse: request accepted.
- done  output  NREQ  one-cycle pulse: result valid.
- result  output  16  result of the last completed op, held until the next done.
- err  output  1  qualifies done: op was illegal or timed out.
- alu_in1, alu_in2  output  16 each  addition unit operands.
- alu_sub  output  1  0 = add, 1 = subtract.
- alu_start  output  1  addition unit start pulse.
- alu_out  input  16  addition unit result.
- alu_finish  input  1  addition unit finish.
- mul_in1, mul_in2  output  16 each  multiply unit operands.
- mul_start  output  1  multiply unit start pulse.
- mul_out  input  16  multiply unit result.
- mul_finish  input  1  multiply unit finish.

Behaviour:
- Reset (asynchronous, any state): every output = 0, state = IDLE, rr pointer = 0 (requester 0 highest priority), latched op/operands = 0. An op in flight is abandoned; the units share nRST.
- States: IDLE, ISSUE, WAIT, RESPOND. All outputs are registered.
- IDLE:
  - Winner = first asserted req at or after the rr pointer, wrapping.
  - Latch winner index, op, opa, opb; pulse gnt[winner] for 1 cycle.
  - Legal op -> ISSUE. Illegal op (not exactly 001/010/100) -> RESPOND with err = 1, result = 0; no unit is started.
  - No req -> stay in IDLE.
- ISSUE:
  - Drive the selected unit's operands from the latches: add/sub -> alu_in1/alu_in2, alu_sub = (op == 010); mul -> mul_in1/mul_in2.
  - Pulse alu_start or mul_start for exactly 1 cycle, then go to WAIT.
  - Operand outputs stay stable from ISSUE until the next ISSUE.
- WAIT:
  - Stay until the selected unit's finish = 1.
  - Capture alu_out or mul_out into result, err = 0, then go to RESPOND.
  - Finish from the non-selected unit, or any finish outside WAIT, is ignored.
- RESPOND:
  - done[winner] = 1 for 1 cycle.
  - rr pointer = (winner + 1) mod NREQ, then go to IDLE.
- Latency:
  - req sampled at edge k -> gnt visible after edge k+1 -> start after edge k+2.
  - finish sampled at edge m -> done after edge m+2.
  - Minimum spacing between back-to-back grants: 4 cycles plus unit latency.
- Requester rules:
  - Hold req/op/opa/opb stable until gnt is seen.
  - req still high after gnt is treated as a new request. It is re-arbitrated in the next IDLE, so another pending requester wins first.
- Simultaneous requests are resolved by the rr pointer only. A request that stays asserted is served within NREQ grants (no starvation).
- Arithmetic: 16-bit two's complement, passed through unchanged. Overflow and truncation are owned by the units.

Optional Feature:
- CALC_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT. On reaching TIMEOUT_CYCLES without the selected finish, go to RESPOND with err = 1, result = 0.
  - The counter clears on entry to WAIT.
  - A late finish from the timed-out unit arriving in IDLE/ISSUE is ignored.
- Not defined: no counter; WAIT holds indefinitely; err is asserted only for illegal ops.

Decomposition:
- calc_pkg holds:
  - opcode localparams OP_ADD = 3'b001, OP_SUB = 3'b010, OP_MUL = 3'b100;
  - the arb_state_t enum (IDLE, ISSUE, WAIT, RESPOND);
  - the shared OPW = 16 width constant.
- Sub-module rr_picker: purely combinational. Inputs req[NREQ-1:0] and pointer; outputs valid and winner index. It is instantiated once and tested standalone.

Test Plan:
- req[0], op = 001, opa = 12, opb = 30; alu_finish 3 cycles after alu_start with alu_out = 42 -> gnt[0], alu_start pulse with alu_sub = 0, done[0], result = 42, err = 0, mul_start never asserted.
- req[1], op = 100, opa = -7, opb = 10; mul_out = -70 -> mul_start once, done[1], result = 0xFFBA, err = 0.
- req[0] and req[1] both held high after reset, op = 010, opa = 5, opb = 9 -> grant order 0,1,0,1; each done returns 0xFFFC.
- req[0], op = 011 -> gnt[0], then done[0] with err = 1, result = 0; no start on either unit.
- nRST low during WAIT -> all outputs 0 immediately. After release, req[1] is granted before req[0] only if req[0] is low.
- With CALC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, mul_finish never asserted -> done pulses 8 cycles into WAIT with err = 1. The next request completes normally.
